// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: word-addressed register port between the CPU data bus and irq_ctrl.
interface irq_ctrl_if;
  logic [2:0]  bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  modport master (output bus_addr, bus_we, bus_wdata, input bus_rdata);
  modport slave (input bus_addr, bus_we, bus_wdata, output bus_rdata);
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: prioritised timer/external interrupt source controller feeding CP0.
module irq_ctrl #(
  parameter int TIMER_WIDTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ext_in,
  irq_ctrl_if.slave   bus,
  output logic        ir_out,
  input  logic        ir_taken,
  input  logic        eret_done,
  output logic [1:0]  ir_id
);
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0][2:0] sync;
  logic [2:0] ext_prev;
  logic [3:0] pending, mask, set, clr, req;
  logic [TIMER_WIDTH-1:0] tcnt, tcmp;
  logic [1:0] tctrl, win, ir_id_n;
  logic match, wr_mask, wr_tcnt, wr_tcmp, wr_tctrl, wr_pclr;
  logic [31:0] rdata_n;
  assign wr_mask  = bus.bus_we && bus.bus_addr == 3'd1;
  assign wr_tcnt  = bus.bus_we && bus.bus_addr == 3'd3;
  assign wr_tcmp  = bus.bus_we && bus.bus_addr == 3'd4;
  assign wr_tctrl = bus.bus_we && bus.bus_addr == 3'd5;
  assign wr_pclr  = bus.bus_we && bus.bus_addr == 3'd6;
  // a write to the timer registers suppresses the compare in that cycle
  assign match = tctrl[0] && tcnt == tcmp && !wr_tcnt && !wr_tcmp;
  assign set = {sync[SYNC_STAGES-1] & ~ext_prev, match};
  assign clr = (wr_pclr ? bus.bus_wdata[3:0] : 4'd0) | (state == REQ && ir_taken ? 4'b1 << ir_id : 4'd0);
  assign req = pending & mask;
  assign win = req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd3;
  assign ir_out = state == REQ;
  always_comb begin
    state_n = state;
    ir_id_n = ir_id;
    case (state)
      IDLE: if (req != 4'd0) begin
        state_n = REQ;
        ir_id_n = win;
      end
      REQ: state_n = ir_taken ? SERVICE : REQ;
      SERVICE: state_n = eret_done ? IDLE : SERVICE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    rdata_n = '0;
    case (bus.bus_addr)
      3'd0: begin
        rdata_n[3:0] = pending;
        rdata_n[9:8] = state;
      end
      3'd1: rdata_n[3:0] = mask;
      3'd2: begin
        rdata_n[1:0] = ir_id;
        rdata_n[31] = state != IDLE;
      end
      3'd3: rdata_n = 32'(tcnt);
      3'd4: rdata_n = 32'(tcmp);
      3'd5: rdata_n[1:0] = tctrl;
      default: rdata_n = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      ext_prev <= '0;
      pending <= '0;
      mask <= '0;
      tcnt <= '0;
      tcmp <= '1;
      tctrl <= '0;
      state <= IDLE;
      ir_id <= '0;
      bus.bus_rdata <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ext_in};
      ext_prev <= sync[SYNC_STAGES-1];
      pending <= (pending & ~clr) | set;
      mask <= wr_mask ? bus.bus_wdata[3:0] : mask;
      tcnt <= wr_tcnt ? bus.bus_wdata[TIMER_WIDTH-1:0] : match ? '0 : tctrl[0] ? tcnt + 1'b1 : tcnt;
      tcmp <= wr_tcmp ? bus.bus_wdata[TIMER_WIDTH-1:0] : tcmp;
      tctrl <= wr_tctrl ? bus.bus_wdata[1:0] : match && !tctrl[1] ? 2'b00 : tctrl;
      state <= state_n;
      ir_id <= ir_id_n;
      bus.bus_rdata <= rdata_n;
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed and random stimulus scored against a behavioural interrupt controller model.
module tb_irq_ctrl;
  localparam int S = 2;
  logic clk = 0, rst = 1;
  logic [2:0] ext_in = '0;
  logic ir_taken = 0, eret_done = 0, ir_out;
  logic [1:0] ir_id;
  irq_ctrl_if bus();
  irq_ctrl #(.TIMER_WIDTH(32), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .ext_in(ext_in), .bus(bus),
    .ir_out(ir_out), .ir_taken(ir_taken), .eret_done(eret_done), .ir_id(ir_id)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  typedef struct {string name; logic [31:0] exp;} exp_t;
  exp_t rd_q[$];
  logic c_vld = 0;
  logic [31:0] c_exp = '0;
  string c_name = "";
  int m_state, m_id;
  bit [3:0] m_pend, m_mask;
  bit [31:0] m_cnt, m_cmp;
  bit [1:0] m_ctrl;
  bit [2:0] hist [S+2];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic bit [31:0] m_read(input int a);
    case (a)
      0: return {22'd0, 2'(m_state), 4'd0, m_pend};
      1: return {28'd0, m_mask};
      2: return {m_state != 0, 29'd0, 2'(m_id)};
      3: return m_cnt;
      4: return m_cmp;
      5: return {30'd0, m_ctrl};
      default: return 32'd0;
    endcase
  endfunction
  // reference model: evaluated once per clock from the rules of the controller
  always @(posedge clk) begin : model
    bit [3:0] sv, cv;
    bit mt;
    int wa;
    if (rst) begin
      rd_q.push_back('{"rdata_reset", 32'd0});
      m_state = 0; m_id = 0; m_pend = 0; m_mask = 0;
      m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_ctrl = 0;
      for (int k = 0; k < S + 2; k++) hist[k] = 0;
    end else begin
      rd_q.push_back('{"rdata", m_read(int'(bus.bus_addr))});
      if (c_vld) rd_q.push_back('{c_name, c_exp});
      for (int k = S + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = ext_in;
      wa = bus.bus_we ? int'(bus.bus_addr) : -1;
      mt = m_ctrl[0] && m_cnt == m_cmp && wa != 3 && wa != 4;
      sv = {hist[S] & ~hist[S+1], mt};
      cv = wa == 6 ? bus.bus_wdata[3:0] : 4'd0;
      if (m_state == 1 && ir_taken) begin
        cv[m_id] = 1;
        m_state = 2;
      end else if (m_state == 2 && eret_done) m_state = 0;
      else if (m_state == 0 && (m_pend & m_mask) != 0) begin
        for (int k = 3; k >= 0; k--) if (m_pend[k] && m_mask[k]) m_id = k;
        m_state = 1;
      end
      m_pend = (m_pend & ~cv) | sv;
      if (wa == 3) m_cnt = bus.bus_wdata;
      else if (mt) m_cnt = 0;
      else if (m_ctrl[0]) m_cnt = m_cnt + 1;
      if (wa == 4) m_cmp = bus.bus_wdata;
      if (wa == 5) m_ctrl = bus.bus_wdata[1:0];
      else if (mt && !m_ctrl[1]) m_ctrl[0] = 0;
      if (wa == 1) m_mask = bus.bus_wdata[3:0];
    end
  end
  always @(negedge clk) begin : monitor
    exp_t e;
    chk("ir_out", ir_out, m_state == 1);
    if (m_state != 0) chk("ir_id", ir_id, m_id);
    while (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      chk(e.name, bus.bus_rdata, e.exp);
    end
  end
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.bus_addr = a; bus.bus_we = 1; bus.bus_wdata = d;
    @(negedge clk);
    bus.bus_we = 0;
  endtask
  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    bus.bus_addr = a; c_vld = 1; c_exp = e; c_name = n;
    @(negedge clk);
    c_vld = 0;
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic taken();
    ir_taken = 1; @(negedge clk); ir_taken = 0;
  endtask
  task automatic eret();
    eret_done = 1; @(negedge clk); eret_done = 0;
  endtask
  task automatic wait_irq(input logic [1:0] id, input string n);
    int k = 0;
    while (!ir_out && k < 100) begin @(negedge clk); k++; end
    chk({n, "_irq"}, ir_out, 1);
    chk({n, "_id"}, ir_id, id);
  endtask
  initial begin
    int k, b;
    bus.bus_addr = 0; bus.bus_we = 0; bus.bus_wdata = 0;
    cyc(3);
    rst = 0;
    chk("rst_irout", ir_out, 0);
    rd(0, 0, "rst_status"); rd(2, 0, "rst_cause"); rd(4, 32'hFFFF_FFFF, "rst_tcmp");
    wr(1, 1); wr(4, 9); wr(5, 1);
    k = 0;
    while (!ir_out && k < 100) begin @(negedge clk); k++; end
    chk("timer_latency", k, 11);
    chk("timer_id", ir_id, 0);
    taken();
    rd(0, 32'h200, "svc_status"); rd(5, 0, "oneshot_tctrl");
    eret();
    rd(0, 0, "idle_status");
    wr(1, 4'hF); wr(3, 0); wr(4, 9); wr(5, 1);
    cyc(7);
    ext_in[2] = 1;
    wait_irq(0, "prio_first");
    taken(); eret();
    wait_irq(3, "prio_second");
    rd(2, 32'h8000_0003, "prio_cause");
    taken(); eret();
    ext_in = 0;
    wr(1, 0); cyc(5);
    ext_in[0] = 1; cyc(4);
    rd(0, 2, "mask_status");
    chk("mask_irout", ir_out, 0);
    wr(6, 2);
    rd(0, 0, "pclr_status");
    ext_in[0] = 0; cyc(4);
    ext_in[0] = 1; cyc(2);
    wr(6, 2);
    rd(0, 2, "setwins_status");
    wr(6, 2);
    ext_in = 3'b010; cyc(10);
    rd(0, 4, "held_status");
    wr(6, 4); cyc(90);
    rd(0, 0, "held_once");
    ext_in = 0;
    wr(3, 0); wr(4, 3); wr(5, 3);
    repeat (6) begin cyc(3); wr(6, 1); end
    rd(5, 3, "reload_tctrl");
    wr(5, 0); wr(6, 1);
    wr(1, 2); cyc(2);
    ext_in[0] = 1;
    wait_irq(1, "rst_req");
    rst = 1; ext_in = 0;
    @(negedge clk);
    rst = 0;
    chk("rst_irout2", ir_out, 0);
    rd(0, 0, "rst_status2");
    repeat (3000) begin
      rst = ($urandom % 500) == 0;
      if ($urandom % 30 == 0) begin
        b = $urandom_range(0, 2);
        ext_in[b] = ~ext_in[b];
      end
      bus.bus_addr = 3'($urandom);
      bus.bus_we = ($urandom % 6) == 0;
      bus.bus_wdata = (bus.bus_addr == 3 || bus.bus_addr == 4) ? $urandom_range(0, 24) : $urandom;
      ir_taken = ($urandom % 8) == 0;
      eret_done = ($urandom % 10) == 0;
      @(negedge clk);
    end
    rst = 0; bus.bus_we = 0; ir_taken = 0; eret_done = 0;
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
